// File: rtl/i2c_reg_ctrl.sv
// i2c_reg_ctrl: register-pointer transaction controller between i2c_peripheral and fabric
// Ports: clk/reset_n (async active-low); start/stop/rw/rx_valid/rx_byte/tx_req from the
// peripheral; tx_byte/ptr_err/wr_strobe/wr_addr back to it; host_we/host_addr/host_wdata/
// host_rdata form a local host port onto the same NUM_REGS x 8 register file.
// Define I2C_REG_AUTOINC_EN to post-increment the pointer after each write commit and tx load.
module i2c_reg_ctrl #(
    parameter int NUM_REGS = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       stop,
    input  logic       rw,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    input  logic       tx_req,
    output logic [7:0] tx_byte,
    output logic       ptr_err,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    input  logic       host_we,
    input  logic [7:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic [7:0] host_rdata
);
    localparam int PTR_W = $clog2(NUM_REGS);

    typedef enum logic [1:0] {IDLE, PTR, WR, RD} state_e;

    state_e           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc;
    logic [7:0]       tx_q, tx_d;
    logic             err_q, err_d;
    logic             stb_q, stb_d;
    logic [7:0]       waddr_q, waddr_d;
    logic [7:0]       regs_q [NUM_REGS];
    logic [7:0]       regs_d [NUM_REGS];

`ifdef I2C_REG_AUTOINC_EN
    assign ptr_inc = (ptr_q == PTR_W'(NUM_REGS - 1)) ? '0 : ptr_q + PTR_W'(1);
`else
    assign ptr_inc = ptr_q;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        tx_d    = tx_q;
        err_d   = err_q;
        stb_d   = 1'b0;
        waddr_d = waddr_q;
        regs_d  = regs_q;
        // host write first so a same-index I2C commit below overrides it
        if (host_we && 32'(host_addr) < NUM_REGS)
            regs_d[host_addr[PTR_W-1:0]] = host_wdata;
        if (start) begin
            state_d = rw ? RD : PTR;
            if (rw) begin
                tx_d  = regs_q[ptr_q];
                ptr_d = ptr_inc;
            end
        end else begin
            case (state_q)
                PTR: if (rx_valid) begin
                    state_d = WR;
                    err_d   = !(32'(rx_byte) < NUM_REGS);
                    ptr_d   = (32'(rx_byte) < NUM_REGS) ? rx_byte[PTR_W-1:0] : ptr_q;
                end
                WR: if (rx_valid && !err_q) begin
                    regs_d[ptr_q] = rx_byte;
                    stb_d         = 1'b1;
                    waddr_d       = 8'(ptr_q);
                    ptr_d         = ptr_inc;
                end
                RD: if (tx_req) begin
                    tx_d  = regs_q[ptr_q];
                    ptr_d = ptr_inc;
                end
                default: ;
            endcase
            // byte action above still completes when stop arrives with it
            if (stop) state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            tx_q    <= '0;
            err_q   <= 1'b0;
            stb_q   <= 1'b0;
            waddr_q <= '0;
            regs_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            tx_q    <= tx_d;
            err_q   <= err_d;
            stb_q   <= stb_d;
            waddr_q <= waddr_d;
            regs_q  <= regs_d;
        end
    end

    assign tx_byte    = tx_q;
    assign ptr_err    = err_q;
    assign wr_strobe  = stb_q;
    assign wr_addr    = waddr_q;
    assign host_rdata = (32'(host_addr) < NUM_REGS) ? regs_q[host_addr[PTR_W-1:0]] : 8'h00;
endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// tb_i2c_reg_ctrl: vector table, hand sequences and random traffic against a transaction-level model
module tb_i2c_reg_ctrl;
    localparam int N = 16;
`ifdef I2C_REG_AUTOINC_EN
    localparam bit AI = 1'b1;
`else
    localparam bit AI = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start, stop, rw, rx_valid, tx_req, host_we;
    logic [7:0] rx_byte, host_addr, host_wdata;
    logic [7:0] tx_byte, wr_addr, host_rdata;
    logic       ptr_err, wr_strobe;

    i2c_reg_ctrl #(.NUM_REGS(N)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .rw(rw),
        .rx_valid(rx_valid), .rx_byte(rx_byte), .tx_req(tx_req), .tx_byte(tx_byte),
        .ptr_err(ptr_err), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // model: transaction phase 0 none, 1 awaiting pointer, 2 writing data, 3 reading
    int         phase, m_ptr, m_waddr;
    logic [7:0] mreg [N];
    logic [7:0] m_tx;
    logic       m_err, m_stb;

    typedef struct {
        logic       s, p, r, rv;
        logic [7:0] rb;
        logic       tr, hw;
        logic [7:0] ha, hd;
        logic [7:0] etx;
        logic       eerr, estb;
        logic [7:0] ewa, ehr;
    } vec_t;
    vec_t tbl[$];
    vec_t t;

    function automatic int nxt(int p);
        return AI ? (p + 1) % N : p;
    endfunction

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (mreg[i]) mreg[i] = 8'h00;
        phase = 0; m_ptr = 0; m_waddr = 0; m_tx = 8'h00; m_err = 1'b0; m_stb = 1'b0;
    endtask

    task automatic model_update(input logic s, p, r, rv, input logic [7:0] rb,
                                input logic tr, hw, input logic [7:0] ha, hd);
        int wi;
        wi = -1;
        m_stb = 1'b0;
        if (s) begin
            phase = r ? 3 : 1;
            if (r) begin m_tx = mreg[m_ptr]; m_ptr = nxt(m_ptr); end
        end else begin
            if (phase == 1 && rv) begin
                phase = 2;
                if (int'(rb) < N) begin m_ptr = int'(rb); m_err = 1'b0; end
                else m_err = 1'b1;
            end else if (phase == 2 && rv && !m_err) begin
                wi = m_ptr; m_stb = 1'b1; m_waddr = m_ptr; m_ptr = nxt(m_ptr);
            end else if (phase == 3 && tr) begin
                m_tx = mreg[m_ptr]; m_ptr = nxt(m_ptr);
            end
            if (p) phase = 0;
        end
        if (hw && int'(ha) < N) mreg[int'(ha)] = hd;
        if (wi >= 0) mreg[wi] = rb;
    endtask

    task automatic compare_all();
        check("tx_byte", tx_byte, m_tx);
        check("ptr_err", {7'b0, ptr_err}, {7'b0, m_err});
        check("wr_strobe", {7'b0, wr_strobe}, {7'b0, m_stb});
        check("wr_addr", wr_addr, 8'(m_waddr));
        check("host_rdata", host_rdata, (int'(host_addr) < N) ? mreg[int'(host_addr)] : 8'h00);
    endtask

    task automatic cyc(input logic s, p, r, rv, input logic [7:0] rb,
                       input logic tr, hw, input logic [7:0] ha, hd);
        start = s; stop = p; rw = r; rx_valid = rv; rx_byte = rb;
        tx_req = tr; host_we = hw; host_addr = ha; host_wdata = hd;
        @(posedge clk);
        if (reset_n) model_update(s, p, r, rv, rb, tr, hw, ha, hd);
        else model_reset();
        #1;
        compare_all();
    endtask

    initial begin
        logic [7:0] tv;
        tv = AI ? 8'h00 : 8'h66;
        //                 s     p     r     rv    rb     tr    hw    ha     hd     etx    eerr  estb  ewa                 ehr
        tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00});
        tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 8'h03, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00});
        tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b1, 8'h66, 1'b0, 1'b0, 8'h03, 8'h00, 8'h00, 1'b0, 1'b1, 8'h03, 8'h66});
        tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h03, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h66});
        tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h04, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00});
        tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 8'h04, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00});
        tbl.push_back(vec_t'{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h03, 8'h00, 8'h66, 1'b0, 1'b0, 8'h00, 8'h66});
        tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h04, 8'h00, tv,    1'b0, 1'b0, 8'h00, 8'h00});
        tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h04, 8'h00, tv,    1'b0, 1'b0, 8'h00, 8'h00});
        tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, tv,    1'b0, 1'b0, 8'h00, 8'h00});
        tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, tv,    1'b0, 1'b0, 8'h00, 8'h00});
        tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b0, 8'h0F, 8'h00, tv,    1'b0, 1'b0, 8'h00, 8'h00});
        tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b0, 8'h0F, 8'h00, tv,    1'b0, 1'b1, 8'h0F, 8'hA1});
        tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b1, 8'hB2, 1'b0, 1'b0, 8'h00, 8'h00, tv,    1'b0, 1'b1, AI ? 8'h00 : 8'h0F, AI ? 8'hB2 : 8'h00});
        tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h0F, 8'h00, tv,    1'b0, 1'b0, 8'h00, AI ? 8'hA1 : 8'hB2});
        tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h0F, 8'h00, tv,    1'b0, 1'b0, 8'h00, AI ? 8'hA1 : 8'hB2});
        tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b1, 8'h20, 1'b0, 1'b0, 8'h0F, 8'h00, tv,    1'b1, 1'b0, 8'h00, AI ? 8'hA1 : 8'hB2});
        tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 8'h0F, 8'h00, tv,    1'b1, 1'b0, 8'h00, AI ? 8'hA1 : 8'hB2});
        tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 8'h00, tv,    1'b1, 1'b0, 8'h00, 8'h00});
        tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 8'h00, tv,    1'b1, 1'b0, 8'h00, 8'h00});
        tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 8'h01, 8'h00, tv,    1'b0, 1'b0, 8'h00, 8'h00});
        tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 8'h00, tv,    1'b0, 1'b0, 8'h00, 8'h00});
        tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h05, 8'h00, tv,    1'b0, 1'b0, 8'h00, 8'h00});
        tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 8'h05, 8'h00, tv,    1'b0, 1'b0, 8'h00, 8'h00});
        tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 8'h05, 8'h11, tv,    1'b0, 1'b1, 8'h05, 8'h22});
        tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h05, 8'h00, tv,    1'b0, 1'b0, 8'h00, 8'h22});
        tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h06, 8'h00, tv,    1'b0, 1'b0, 8'h00, 8'h00});
        tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 8'h06, 8'h00, tv,    1'b0, 1'b0, 8'h00, 8'h00});
        tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 8'h06, 8'h11, tv,    1'b0, 1'b1, 8'h05, 8'h11});
        tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h05, 8'h00, tv,    1'b0, 1'b0, 8'h00, 8'h22});

        reset_n = 1'b0;
        {start, stop, rw, rx_valid, tx_req, host_we} = '0;
        rx_byte = 8'h00; host_addr = 8'h00; host_wdata = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", tx_byte, 8'h00);
        check("rst_err", {7'b0, ptr_err}, 8'h00);
        check("rst_stb", {7'b0, wr_strobe}, 8'h00);
        check("rst_waddr", wr_addr, 8'h00);
        check("rst_hrdata", host_rdata, 8'h00);
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            t = tbl[i];
            cyc(t.s, t.p, t.r, t.rv, t.rb, t.tr, t.hw, t.ha, t.hd);
            check($sformatf("tbl%0d_tx", i), tx_byte, t.etx);
            check($sformatf("tbl%0d_err", i), {7'b0, ptr_err}, {7'b0, t.eerr});
            check($sformatf("tbl%0d_stb", i), {7'b0, wr_strobe}, {7'b0, t.estb});
            if (t.estb) check($sformatf("tbl%0d_waddr", i), wr_addr, t.ewa);
            check($sformatf("tbl%0d_hrdata", i), host_rdata, t.ehr);
        end

        // reset between the pointer byte and the data byte
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h05, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h07, 1'b0, 1'b0, 8'h05, 8'h00);
        rx_valid = 1'b1; rx_byte = 8'h99;
        reset_n = 1'b0;
        #2;
        check("async_rst_stb", {7'b0, wr_strobe}, 8'h00);
        check("async_rst_hrdata5", host_rdata, 8'h00);
        model_reset();
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h99, 1'b0, 1'b0, 8'h07, 8'h00);
        reset_n = 1'b1;
        for (int a = 0; a < N; a++) begin
            host_addr = 8'(a);
            #1;
            check($sformatf("rst_reg%0d", a), host_rdata, 8'h00);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h44, 1'b0, 1'b0, 8'h00, 8'h00);
        check("post_rst_idle_stb", {7'b0, wr_strobe}, 8'h00);
        check("post_rst_idle_reg0", host_rdata, 8'h00);

        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0, 1'($urandom),
                $urandom_range(0, 2) == 0,
                ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, N - 1)),
                $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                8'($urandom_range(0, 2 * N - 1)), 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/i2c_reg_ctrl.md
# i2c_reg_ctrl

Byte-level transaction controller that sits between `i2c_peripheral` and the FPGA fabric. It interprets the peripheral's received bytes and transaction direction as a register-pointer protocol. It owns a small register file shared between the I2C bus and a local host port, and it supplies the next transmit byte on reads.

## Interface

Parameters:
- `NUM_REGS`, 16: register count; legal range 2..256. Pointer width is `PTR_W = $clog2(NUM_REGS)`.

Ports:
- `clk`  in  1  system clock; all inputs sampled on its rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle pulse after address match on START or repeated START.
- `stop`  in  1  one-cycle pulse on STOP.
- `rw`  in  1  transaction direction, valid with `start`; 1 = bus read.
- `rx_valid`  in  1  one-cycle pulse when a received byte has been ACKed.
- `rx_byte`  in  8  received byte, valid with `rx_valid`.
- `tx_req`  in  1  one-cycle pulse when the peripheral has latched `tx_byte` and needs the next byte.
- `tx_byte`  out  8  byte the peripheral transmits next.
- `ptr_err`  out  1  sticky flag: the last pointer byte was ≥ `NUM_REGS`.
- `wr_strobe`  out  1  one-cycle pulse when an I2C write commits.
- `wr_addr`  out  8  register index of the commit, valid with `wr_strobe`.
- `host_we`  in  1  host write enable.
- `host_addr`  in  8  host register index.
- `host_wdata`  in  8  host write data.
- `host_rdata`  out  8  `reg[host_addr]`, combinational; 0x00 if `host_addr` ≥ `NUM_REGS`.

All pulse inputs are synchronous to `clk`. The peripheral side performs synchronization.

## Operation

States:
- `IDLE`: no transaction in progress.
  - `start` & !`rw` → `PTR`.
  - `start` & `rw` → `RD`, loading `tx_byte <= reg[ptr]` and `ptr <= ptr+1`.
- `PTR`: waiting for the pointer byte.
  - `rx_valid` → `WR`.
  - If `rx_byte` < `NUM_REGS`: `ptr <= rx_byte`, clear `ptr_err`.
  - Otherwise: set `ptr_err` and leave `ptr` unchanged.
- `WR`: each `rx_valid` commits `reg[ptr] <= rx_byte`, pulses `wr_strobe` with `wr_addr = ptr`, and sets `ptr <= ptr+1`.
  - If `ptr_err` is set, bytes are discarded and produce no strobe.
- `RD`: each `tx_req` sets `tx_byte <= reg[ptr]` and `ptr <= ptr+1`.
- `stop` in any state → `IDLE`. `ptr` is retained across transactions.
- `start` in any state restarts per the `IDLE` rules (repeated START).
- Pointer wrap: incrementing from `NUM_REGS-1` wraps to 0.

Concurrency and priority:
- Host and I2C writes in the same cycle to different indices: both commit.
- Host and I2C writes to the same index: the I2C write wins and `wr_strobe` fires.
- `start` and `stop` in the same cycle: `start` wins.
- `rx_valid` or `tx_req` together with `stop`: the byte action completes, then the next state is `IDLE`.
- `rx_valid` or `tx_req` together with `start`: the byte action is ignored and `start` is processed.
- `rx_valid` in `IDLE` or `RD`, and `tx_req` in `IDLE`, `PTR` or `WR`: ignored.
- Host writes to indices ≥ `NUM_REGS`: ignored.

## Timing

- Reset values:
  - State `IDLE`, `ptr` = 0, all registers 0x00.
  - `tx_byte` = 0x00, `ptr_err` = 0, `wr_strobe` = 0, `wr_addr` = 0x00.
  - `host_rdata` follows `reg[host_addr]` = 0x00.
- Reset asserted mid-transaction aborts it immediately. No strobe is emitted after reset asserts.
- I2C write latency: `reg` updates at the edge sampling `rx_valid`. `wr_strobe` is high the following cycle. `host_rdata` shows the new value the cycle after that edge.
- Read latency: `tx_byte` is valid one cycle after `start` or `tx_req`. The peripheral must not sample it earlier; it has ≥8 SCL periods of slack.
- Back-to-back `rx_valid` or `tx_req` on consecutive cycles must be supported.

## Configuration

- `I2C_REG_AUTOINC_EN` defined: `ptr` post-increments after every committed write and every `tx_byte` load, wrapping as above.
- Undefined: `ptr` changes only on a pointer byte. Repeated writes overwrite the same register, and repeated reads return the same register.

## Test plan

- Write: `start`/`rw`=0, `rx_byte` 0x03 then 0x66, `stop` → `reg[3]`=0x66; one `wr_strobe` with `wr_addr`=3; `ptr`=4 (AUTOINC_EN).
- Read after write: from the previous state, send pointer 0x03 with `rw`=0, then repeated `start` with `rw`=1, then `tx_req` ×2 → `tx_byte` sequence 0x66, `reg[4]`=0x00. Without AUTOINC_EN → 0x66, 0x66.
- Wrap: pointer `NUM_REGS-1` (0x0F), write 0xA1, 0xB2 → `reg[15]`=0xA1, `reg[0]`=0xB2.
- Bad pointer: pointer 0x20 → `ptr_err`=1; the following data byte 0x55 causes no strobe and no register change. A next valid pointer 0x01 clears `ptr_err`.
- Collision: host writes 0x11 to index 5 in the same cycle as an I2C commit of 0x22 to index 5 → `reg[5]`=0x22. Repeat with host index 6 → `reg[6]`=0x11 and `reg[5]`=0x22.
- Reset mid-write: assert `reset_n`=0 between the pointer byte and the data byte → all registers 0x00, state `IDLE`, no `wr_strobe`.
